// File: rtl/dmem_pkg.sv
// Shared definitions for the handshaked data memory and its lane-alignment helper.
// No logic lives here: only funct3 encodings, the FSM state type and the word width.
package dmem_pkg;

  localparam int WORD_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Sub-word lane steering: byte enables, replicated store data, extended load data, misalign/illegal flag.
// Purely combinational (zero latency); it has no handshake, so it never applies backpressure.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        lane,
  input  logic [WORD_W-1:0] wdata,
  input  logic [WORD_W-1:0] rdword,
  output logic [3:0]        byte_en,
  output logic [WORD_W-1:0] wword,
  output logic [WORD_W-1:0] rdata_ext,
  output logic              bad
);

  logic [WORD_W-1:0] shifted;

  always_comb begin
    shifted   = rdword >> {lane, 3'b000};
    byte_en   = 4'b0000;
    wword     = wdata;
    rdata_ext = '0;
    bad       = 1'b0;
    // Store data is replicated across lanes so the byte enables alone select the target bytes
    case (funct3)
      F3_B, F3_BU: begin
        byte_en   = 4'b0001 << lane;
        wword     = {4{wdata[7:0]}};
        rdata_ext = (funct3 == F3_B) ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        bad       = lane[0];
        byte_en   = 4'b0011 << lane;
        wword     = {2{wdata[15:0]}};
        rdata_ext = (funct3 == F3_H) ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
      end
      F3_W: begin
        bad       = (lane != 2'b00);
        byte_en   = 4'b1111;
        rdata_ext = shifted;
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory_hs.sv
// Word RAM with RISC-V sub-word access behind a valid/ready request/response handshake.
// Response 1+WAIT_STATES cycles after accept; one access in flight, req_ready low until the response is taken.
module data_memory_hs
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              cap_write;
  logic [2:0]        cap_funct3;
  logic [ADDR_W-1:0] cap_addr;
  logic [WORD_W-1:0] cap_wdata;
  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  logic              accept;
  logic              exec;
  logic              ex_write;
  logic [2:0]        ex_funct3;
  logic [ADDR_W-1:0] ex_addr;
  logic [WORD_W-1:0] ex_wdata;
  logic [IDX_W-1:0]  ex_idx;
  logic              out_of_range;
  logic              err;
  logic [3:0]        byte_en;
  logic [WORD_W-1:0] wword;
  logic [WORD_W-1:0] rdata_ext;
  logic              bad;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // With no wait states the access runs straight off the live request on the accept edge
  always_comb begin
    if (WAIT_STATES == 0) begin
      ex_write  = req_write;
      ex_funct3 = req_funct3;
      ex_addr   = req_addr;
      ex_wdata  = req_wdata;
      exec      = accept;
    end else begin
      ex_write  = cap_write;
      ex_funct3 = cap_funct3;
      ex_addr   = cap_addr;
      ex_wdata  = cap_wdata;
      exec      = (state == WAIT) && (wait_cnt == 4'd0);
    end
  end

  assign ex_idx       = ex_addr[IDX_W+1:2];
  assign out_of_range = |ex_addr[ADDR_W-1:IDX_W+2];
  assign err          = bad || out_of_range || (ex_write && ex_funct3[2]);

  dmem_lane_align u_align (
    .funct3    (ex_funct3),
    .lane      (ex_addr[1:0]),
    .wdata     (ex_wdata),
    .rdword    (mem[ex_idx]),
    .byte_en   (byte_en),
    .wword     (wword),
    .rdata_ext (rdata_ext),
    .bad       (bad)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      cap_write  <= 1'b0;
      cap_funct3 <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              cap_write  <= req_write;
              cap_funct3 <= req_funct3;
              cap_addr   <= req_addr;
              cap_wdata  <= req_wdata;
              wait_cnt   <= 4'(WAIT_STATES - 1);
              state      <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (exec) begin
        rsp_valid <= 1'b1;
        rsp_err   <= err;
        rsp_rdata <= (err || ex_write) ? '0 : rdata_ext;
        if (!err && ex_write) begin
          for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem[ex_idx][8*b +: 8] <= wword[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: one instance with no wait states, one with three, checked against a byte-array model.
// Directed steps followed by randomized accesses; each comparison is an immediate assertion.
module tb_data_memory_hs;

  logic        clk = 1'b0;
  logic        rst0 = 1'b1;
  logic        rst3 = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  bit          sel = 1'b0;

  logic        rdy0, vld0, err0, rdy3, vld3, err3;
  logic [31:0] rdata0, rdata3;
  logic        cur_rdy, cur_vld, cur_err;
  logic [31:0] cur_rdata;

  logic [7:0]  mref [2][256];
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  data_memory_hs #(.DEPTH_WORDS(64), .ADDR_W(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst0),
    .req_valid(req_valid && !sel), .req_ready(rdy0), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld0), .rsp_ready(rsp_ready && !sel), .rsp_rdata(rdata0), .rsp_err(err0)
  );

  data_memory_hs #(.DEPTH_WORDS(64), .ADDR_W(32), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst3),
    .req_valid(req_valid && sel), .req_ready(rdy3), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld3), .rsp_ready(rsp_ready && sel), .rsp_rdata(rdata3), .rsp_err(err3)
  );

  assign cur_rdy   = sel ? rdy3   : rdy0;
  assign cur_vld   = sel ? vld3   : vld0;
  assign cur_err   = sel ? err3   : err0;
  assign cur_rdata = sel ? rdata3 : rdata0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: memory as a flat little-endian byte array, access rules applied directly
  task automatic model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output bit e, output logic [31:0] rd);
    int sz;
    logic [31:0] v;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || ((a % 32'(sz)) != 0) ||
         (a >= 32'd256) || (w && f3[2]);
    rd = '0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < sz; i++) mref[sel][int'(a) + i] = d[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < sz; i++) v = v | (32'(mref[sel][int'(a) + i]) << (8*i));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
        rd = v;
      end
    end
  endtask

  task automatic xact(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                      input int stall, input string tag, output logic [31:0] got);
    bit          e_err;
    logic [31:0] e_rd;
    int          n;
    int          lat;
    model(w, f3, a, d, e_err, e_rd);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
    n = 0;
    while (!cur_rdy && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!cur_vld && lat < 40) begin @(negedge clk); lat++; end
    chk({tag, "_lat"}, 32'(lat), sel ? 32'd4 : 32'd1);
    chk({tag, "_err"}, {31'b0, cur_err}, {31'b0, e_err});
    chk({tag, "_rdata"}, cur_rdata, e_rd);
    got = cur_rdata;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "_hold_vld"}, {31'b0, cur_vld}, 32'd1);
      chk({tag, "_hold_rdata"}, cur_rdata, e_rd);
      chk({tag, "_hold_rdy"}, {31'b0, cur_rdy}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_done_vld"}, {31'b0, cur_vld}, 32'd0);
    chk({tag, "_done_rdy"}, {31'b0, cur_rdy}, 32'd1);
  endtask

  task automatic do_reset(input bit s);
    sel = s;
    @(negedge clk);
    if (s) rst3 = 1'b1; else rst0 = 1'b1;
    @(negedge clk);
    chk("rst_rdy_low", {31'b0, cur_rdy}, 32'd0);
    if (s) rst3 = 1'b0; else rst0 = 1'b0;
    for (int i = 0; i < 256; i++) mref[s][i] = 8'h00;
    chk("rst_vld", {31'b0, cur_vld}, 32'd0);
    chk("rst_err", {31'b0, cur_err}, 32'd0);
    chk("rst_rdata", cur_rdata, 32'd0);
    @(negedge clk);
    chk("rst_rdy_high", {31'b0, cur_rdy}, 32'd1);
  endtask

  task automatic random_run(input int count, input int max_stall);
    logic [31:0] g;
    logic [31:0] a;
    for (int k = 0; k < count; k++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'd256 + $urandom_range(0, 15);
        default: a = $urandom_range(0, 255);
      endcase
      xact(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom,
           int'($urandom_range(0, max_stall)), "rnd", g);
    end
  endtask

  initial begin
    logic [31:0] g;
    repeat (2) @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0;

    // No wait states: directed sub-word sequence
    do_reset(1'b0);
    xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, "sw10", g);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 1, "lw10", g);
    chk("lw10_const", g, 32'hDEADBEEF);
    xact(1'b1, 3'b000, 32'h11, 32'h000000AA, 0, "sb11", g);
    xact(1'b0, 3'b000, 32'h11, 32'h0, 0, "lb11", g);
    chk("lb11_const", g, 32'hFFFFFFAA);
    xact(1'b0, 3'b100, 32'h11, 32'h0, 0, "lbu11", g);
    chk("lbu11_const", g, 32'h000000AA);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw10b", g);
    chk("lw10b_const", g, 32'hDEADAAEF);
    xact(1'b1, 3'b001, 32'h12, 32'h00008001, 0, "sh12", g);
    xact(1'b0, 3'b001, 32'h12, 32'h0, 0, "lh12", g);
    chk("lh12_const", g, 32'hFFFF8001);
    xact(1'b0, 3'b101, 32'h12, 32'h0, 0, "lhu12", g);
    chk("lhu12_const", g, 32'h00008001);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw10c", g);
    chk("lw10c_const", g, 32'h8001AAEF);

    // Rejected accesses leave memory untouched
    xact(1'b0, 3'b010, 32'h13, 32'h0, 0, "err_lw13", g);
    xact(1'b0, 3'b001, 32'h11, 32'h0, 0, "err_lh11", g);
    xact(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 0, "err_f3_011", g);
    xact(1'b0, 3'b010, 32'h100, 32'h0, 0, "err_range", g);
    xact(1'b1, 3'b100, 32'h10, 32'h00000055, 0, "err_sbu", g);
    xact(1'b1, 3'b010, 32'h8000_0010, 32'h11111111, 0, "err_hiaddr", g);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw10d", g);
    chk("lw10d_unchanged", g, 32'h8001AAEF);
    random_run(80, 1);

    // Three wait states: latency, held response, mid-operation reset
    do_reset(1'b1);
    xact(1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 2, "ws_sw30", g);
    xact(1'b0, 3'b010, 32'h30, 32'h0, 2, "ws_lw30", g);
    chk("ws_lw30_const", g, 32'hCAFEF00D);

    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_rdy_busy", {31'b0, cur_rdy}, 32'd0);
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy", {31'b0, cur_rdy}, 32'd0);
    rst3 = 1'b0;
    for (int i = 0; i < 256; i++) mref[1][i] = 8'h00;
    @(negedge clk);
    chk("mid_after_rdy", {31'b0, cur_rdy}, 32'd1);
    chk("mid_after_vld", {31'b0, cur_vld}, 32'd0);
    xact(1'b0, 3'b010, 32'h20, 32'h0, 0, "mid_lw20", g);
    chk("mid_lw20_zero", g, 32'h0);
    xact(1'b0, 3'b010, 32'h30, 32'h0, 0, "mid_lw30", g);
    chk("mid_lw30_cleared", g, 32'h0);
    random_run(50, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
